// File: rtl/product_window_accumulator_pkg.sv
// Shared types and width helper for the product window accumulator.
package product_window_accumulator_pkg;

  typedef enum logic [0:0] {
    ST_ACCUM = 1'b0,
    ST_DONE  = 1'b1
  } state_e;

  // Sum width that can hold WINDOW full-scale products without overflow.
  function automatic int acc_nbits(input int p_nbits, input int window);
    return p_nbits + $clog2(window);
  endfunction

endpackage

// File: rtl/product_window_accumulator_if.sv
// Product input stream and window-sum output stream, both val/rdy handshaked.
interface product_window_accumulator_if #(
  parameter int P_NBITS = 32,
  parameter int A_NBITS = 37
);
  logic               in_val;
  logic               in_rdy;
  logic [P_NBITS-1:0] in_msg;
  logic               out_val;
  logic               out_rdy;
  logic [A_NBITS-1:0] out_msg;

  modport master (
    output in_val, in_msg, out_rdy,
    input  in_rdy, out_val, out_msg
  );

  modport slave (
    input  in_val, in_msg, out_rdy,
    output in_rdy, out_val, out_msg
  );
endinterface

// File: rtl/product_window_accumulator_dpath.sv
// Accumulator datapath: sign-extends each product and adds it to acc or to 0.
// Plain ripple adder with carry in/out, sized by parameter.
module vc_Adder #(
  parameter int p_nbits = 32
) (
  input  logic [p_nbits-1:0] in0,
  input  logic [p_nbits-1:0] in1,
  input  logic               cin,
  output logic [p_nbits-1:0] out,
  output logic               cout
);
  logic [p_nbits:0] sum;

  assign sum  = {1'b0, in0} + {1'b0, in1} + {{p_nbits{1'b0}}, cin};
  assign out  = sum[p_nbits-1:0];
  assign cout = sum[p_nbits];
endmodule

module product_window_accumulator_dpath
  import product_window_accumulator_pkg::*;
#(
  parameter int P_NBITS = 32,
  parameter int A_NBITS = 37
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               acc_clr,
  input  logic               acc_en,
  input  logic               op_zero,
  input  logic [P_NBITS-1:0] in_msg,
  output logic [A_NBITS-1:0] acc
);
  logic [A_NBITS-1:0] in_sext;
  logic [A_NBITS-1:0] operand;
  logic [A_NBITS-1:0] sum;
  logic               adder_cout_unused;

  assign in_sext = {{(A_NBITS-P_NBITS){in_msg[P_NBITS-1]}}, in_msg};
  // op_zero starts a fresh window with the overlapping product.
  assign operand = op_zero ? '0 : acc;

  vc_Adder #(.p_nbits(A_NBITS)) adder (
    .in0  (operand),
    .in1  (in_sext),
    .cin  (1'b0),
    .out  (sum),
    .cout (adder_cout_unused)
  );

  always_ff @(posedge clk) begin
    if (reset || acc_clr) begin
      acc <= '0;
    end else if (acc_en) begin
      acc <= sum;
    end
  end
endmodule

// File: rtl/product_window_accumulator.sv
// Sums WINDOW consecutive signed products into one sum; sum valid the cycle after the last product.
// While a sum is held, in_rdy follows out_rdy so a new window may start in the same cycle.
module product_window_accumulator
  import product_window_accumulator_pkg::*;
#(
  parameter int P_NBITS = 32,
  parameter int WINDOW  = 25,
  parameter int A_NBITS = acc_nbits(P_NBITS, WINDOW)
) (
  input logic                  clk,
  input logic                  reset,
  product_window_accumulator_if.slave bus
);
  localparam int CNT_W = $clog2(WINDOW);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WINDOW - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  localparam logic [0:0] ACCUM = ST_ACCUM;
  localparam logic [0:0] DONE  = ST_DONE;

  logic [0:0]         state;
  logic [CNT_W-1:0]   count;
  logic               in_xfer;
  logic               out_xfer;
  logic               acc_clr;
  logic               acc_en;
  logic               op_zero;
  logic [A_NBITS-1:0] acc;

  assign bus.out_val = (state == DONE);
  assign bus.in_rdy  = (state == ACCUM) || bus.out_rdy;
  assign bus.out_msg = acc;

  assign in_xfer  = bus.in_val && bus.in_rdy;
  assign out_xfer = bus.out_val && bus.out_rdy;

  always_comb begin
    acc_clr = 1'b0;
    acc_en  = 1'b0;
    op_zero = 1'b0;
    if (state == ACCUM) begin
      acc_en = in_xfer;
    end else if (out_xfer) begin
      if (in_xfer) begin
        acc_en  = 1'b1;
        op_zero = 1'b1;
      end else begin
        acc_clr = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ACCUM;
      count <= '0;
    end else begin
      case (state)
        ACCUM: begin
          if (in_xfer) begin
            if (count == CNT_LAST) begin
              count <= '0;
              state <= DONE;
            end else begin
              count <= count + CNT_ONE;
            end
          end
        end
        default: begin
          if (out_xfer) begin
            state <= ACCUM;
            count <= in_xfer ? CNT_ONE : '0;
          end
        end
      endcase
    end
  end

  product_window_accumulator_dpath #(
    .P_NBITS (P_NBITS),
    .A_NBITS (A_NBITS)
  ) dpath (
    .clk     (clk),
    .reset   (reset),
    .acc_clr (acc_clr),
    .acc_en  (acc_en),
    .op_zero (op_zero),
    .in_msg  (bus.in_msg),
    .acc     (acc)
  );
endmodule

// File: tb/tb_product_window_accumulator.sv
// Directed and random stimulus against a window-list reference model of the accumulator.
module tb_product_window_accumulator;
  localparam int P = 8;
  localparam int W = 4;
  localparam int A = 10;

  logic clk = 1'b0;
  logic reset = 1'b1;

  product_window_accumulator_if #(.P_NBITS(P), .A_NBITS(A)) bus ();

  product_window_accumulator #(.P_NBITS(P), .WINDOW(W), .A_NBITS(A)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;

  // Reference model: products of the open window, plus any completed sum awaiting pickup.
  int win[$];
  bit pending = 1'b0;
  int held = 0;
  bit after_reset = 1'b0;

  task automatic chk(input string tag, input int got, input int exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic step(input bit rst, input bit v, input int m, input bit ordy);
    bit in_x;
    bit out_x;
    int s;
    @(negedge clk);
    reset       = rst;
    bus.in_val  = v;
    bus.in_msg  = 8'(m);
    bus.out_rdy = ordy;
    #1;
    chk("out_val", int'(bus.out_val), int'(pending));
    if (pending) chk("out_msg", int'($signed(bus.out_msg)), held);
    if (after_reset) chk("out_msg_after_reset", int'($signed(bus.out_msg)), 0);
    chk("in_rdy", int'(bus.in_rdy), int'(!pending || ordy));
    in_x  = v && (!pending || ordy) && !rst;
    out_x = pending && ordy && !rst;
    after_reset = rst;
    if (rst) begin
      win.delete();
      pending = 1'b0;
    end else begin
      if (out_x) pending = 1'b0;
      if (in_x) begin
        win.push_back(m);
        if (win.size() == W) begin
          s = 0;
          foreach (win[i]) s += win[i];
          held = s;
          pending = 1'b1;
          win.delete();
        end
      end
    end
  endtask

  task automatic idle(input int n, input bit ordy);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 0, ordy);
  endtask

  initial begin
    int vals1[4];
    bit gap_v[7];
    int gi;
    logic [7:0] rb;

    bus.in_val  = 1'b0;
    bus.in_msg  = '0;
    bus.out_rdy = 1'b0;

    step(1'b1, 1'b0, 0, 1'b0);
    step(1'b1, 1'b0, 0, 1'b0);
    idle(1, 1'b1);

    // Basic window with latency check.
    vals1 = '{3, -5, 7, 2};
    foreach (vals1[i]) step(1'b0, 1'b1, vals1[i], 1'b1);
    idle(2, 1'b1);

    // Extremes back-to-back, overlap on the 5th product.
    for (int i = 0; i < W; i++) step(1'b0, 1'b1, -128, 1'b1);
    for (int i = 0; i < W; i++) step(1'b0, 1'b1, 127, 1'b1);
    idle(2, 1'b1);

    // Backpressure: held sum with in_val asserted.
    for (int i = 0; i < W; i++) step(1'b0, 1'b1, i * 11 - 20, 1'b1);
    for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 99, 1'b0);
    step(1'b0, 1'b1, 9, 1'b1);
    idle(1, 1'b1);
    for (int i = 0; i < W - 1; i++) step(1'b0, 1'b1, 1, 1'b1);
    idle(2, 1'b1);

    // Gaps between products.
    gap_v = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    gi = 1;
    foreach (gap_v[i]) begin
      step(1'b0, gap_v[i], gap_v[i] ? gi : 77, 1'b1);
      if (gap_v[i]) gi++;
    end
    idle(2, 1'b1);

    // Reset mid-window.
    step(1'b0, 1'b1, 5, 1'b1);
    step(1'b0, 1'b1, 6, 1'b1);
    step(1'b1, 1'b0, 0, 1'b1);
    for (int i = 0; i < W; i++) step(1'b0, 1'b1, 1, 1'b1);
    idle(2, 1'b1);

    // Reset while holding a sum.
    for (int i = 0; i < W; i++) step(1'b0, 1'b1, 40, 1'b0);
    idle(2, 1'b0);
    step(1'b1, 1'b1, 3, 1'b0);
    for (int i = 0; i < W; i++) step(1'b0, 1'b1, -i - 1, 1'b1);
    idle(2, 1'b1);

    // Random traffic with occasional resets.
    for (int i = 0; i < 3000; i++) begin
      rb = 8'($urandom);
      step(($urandom_range(0, 199) == 0), ($urandom_range(0, 9) < 7),
           int'($signed(rb)), ($urandom_range(0, 9) < 6));
    end
    idle(3, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
